rr_mux_arbiter: RTL and testbench

- Sequencing controller for the shared 2:1/N:1 mux datapath: N requesters compete for one output channel.
- Grants one requester at a time using round-robin arbitration and locks the grant for a whole packet, delimited by a `last` flag.
- Drives the mux select as a one-hot `grant` vector and presents the selected stream through a one-entry registered output stage with valid/ready handshake.
- Sits between requester sources and the single downstream consumer.

---
 rtl/rr_mux_arbiter_if.sv | 27 ++
 rtl/rr_mux_arbiter.sv | 149 ++++++++++++++
 tb/tb_rr_mux_arbiter.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rr_mux_arbiter_if.sv
// Requester-side and consumer-side signals of the round-robin packet mux.
// master = requesters/consumer (drives beats and out_ready); slave = arbiter.
interface rr_mux_arbiter_if #(
   parameter int N = 4,
   parameter int W = 8
);
   logic [N-1:0]   req_valid;
   logic [N*W-1:0] req_data;
   logic [N-1:0]   req_last;
   logic [N-1:0]   req_ready;
   logic           out_valid;
   logic [W-1:0]   out_data;
   logic           out_last;
   logic           out_ready;
   logic [N-1:0]   grant;
   logic           busy;

   modport master (
      output req_valid, req_data, req_last, out_ready,
      input  req_ready, out_valid, out_data, out_last, grant, busy
   );

   modport slave (
      input  req_valid, req_data, req_last, out_ready,
      output req_ready, out_valid, out_data, out_last, grant, busy
   );
endinterface

// File: rtl/rr_mux_arbiter.sv
// Round-robin N:1 packet mux: grant locked per packet, one-entry output register.
// Latency: grant 1 cycle after request, beat 1 cycle later; stalls req_ready while output is full and unready.
module rr_mux_arbiter #(
   parameter int N = 4,
   parameter int W = 8
) (
   input  logic            clk,
   input  logic            rst,
   rr_mux_arbiter_if.slave bus
);

   localparam int PW = (N > 1) ? $clog2(N) : 1;

   localparam logic [0:0] IDLE   = 1'b0;
   localparam logic [0:0] LOCKED = 1'b1;

   logic [0:0]    state;
   logic [PW-1:0] ptr;
   logic [PW-1:0] gidx;
   logic [N-1:0]  grant_q;

   logic          out_valid_q;
   logic [W-1:0]  out_data_q;
   logic          out_last_q;

   logic          win_found;
   logic [PW-1:0] win_idx;
   logic [N-1:0]  win_onehot;
   logic [PW-1:0] ptr_next;
   logic          load_ok;
   logic [N-1:0]  ready_vec;
   logic          xfer;
   logic [W-1:0]  sel_data;
   logic          sel_last;

   // Scan downward so the closest valid index at/after p is written last and wins.
   function automatic logic [PW:0] rr_pick(input logic [N-1:0] v, input logic [PW-1:0] p);
      logic [PW:0] res;
      int          j;
      res = '0;
      for (int k = N - 1; k >= 0; k--) begin
         j = int'(p) + k;
         if (j >= N) j = j - N;
         if (v[j]) res = {1'b1, PW'(j)};
      end
      return res;
   endfunction

   function automatic logic [N-1:0] to_onehot(input logic [PW-1:0] idx);
      logic [N-1:0] r;
      r = '0;
      for (int i = 0; i < N; i++) begin
         if (PW'(i) == idx) r[i] = 1'b1;
      end
      return r;
   endfunction

   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      {win_found, win_idx} = rr_pick(bus.req_valid, ptr);
   end

   assign win_onehot = to_onehot(win_idx);
   assign ptr_next   = (gidx == PW'(N - 1)) ? '0 : gidx + PW'(1);

   // AND-OR mux keyed directly off the one-hot grant register.
   always_comb begin
      sel_data = '0;
      sel_last = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (grant_q[i]) begin
            sel_data = sel_data | bus.req_data[i*W +: W];
            sel_last = sel_last | bus.req_last[i];
         end
      end
   end

   assign load_ok = !out_valid_q || bus.out_ready;

   always_comb begin
      ready_vec = '0;
      if (state == LOCKED && load_ok) ready_vec = grant_q;
   end

   assign xfer = |(bus.req_valid & ready_vec);

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         ptr         <= '0;
         gidx        <= '0;
         grant_q     <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (win_found) begin
                  state   <= LOCKED;
                  gidx    <= win_idx;
                  grant_q <= win_onehot;
               end
            end
            LOCKED: begin
               if (xfer && sel_last) begin
                  state   <= IDLE;
                  grant_q <= '0;
                  ptr     <= ptr_next;
               end
            end
            default: begin
               state   <= IDLE;
               grant_q <= '0;
            end
         endcase

         // Load has priority over drain so a simultaneous drain+load sustains 1 beat/cycle.
         if (xfer) begin
            out_valid_q <= 1'b1;
            out_data_q  <= sel_data;
            out_last_q  <= sel_last;
         end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   assign bus.req_ready = ready_vec;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_last  = out_last_q;
   assign bus.grant     = grant_q;
   assign bus.busy      = (state == LOCKED);

   a_grant_onehot: assert property (@(posedge clk) disable iff (rst)
      $onehot0(grant_q));

   a_busy_matches_grant: assert property (@(posedge clk) disable iff (rst)
      (state == LOCKED) == (grant_q != '0));

   a_out_hold: assert property (@(posedge clk) disable iff (rst)
      (out_valid_q && !bus.out_ready) |=> (out_valid_q && $stable(out_data_q) && $stable(out_last_q)));

   a_grant_locked: assert property (@(posedge clk) disable iff (rst)
      ((state == LOCKED) && !(xfer && sel_last)) |=> $stable(grant_q));

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter (N=4, W=8): reset, single packet, round-robin,
// backpressure, grant lock, and reset mid-packet, all with hand-derived expectations.
module tb_rr_mux_arbiter;
   localparam int N = 4;
   localparam int W = 8;

   logic clk = 1'b0;
   logic rst;
   int   tests_run    = 0;
   int   tests_failed = 0;

   rr_mux_arbiter_if #(.N(N), .W(W)) bus ();

   rr_mux_arbiter #(.N(N), .W(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #20000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drv(input int i, input logic v, input logic [W-1:0] d, input logic l);
      bus.req_valid[i]       = v;
      bus.req_data[i*W +: W] = d;
      bus.req_last[i]        = l;
   endtask

   task automatic idle_all();
      bus.req_valid = '0;
      bus.req_data  = '0;
      bus.req_last  = '0;
   endtask

   task automatic chk_reset_vals(input string pfx);
      chk({pfx, "_out_valid"}, 32'(bus.out_valid), 32'h0);
      chk({pfx, "_out_data"},  32'(bus.out_data),  32'h0);
      chk({pfx, "_out_last"},  32'(bus.out_last),  32'h0);
      chk({pfx, "_grant"},     32'(bus.grant),     32'h0);
      chk({pfx, "_busy"},      32'(bus.busy),      32'h0);
      chk({pfx, "_req_ready"}, 32'(bus.req_ready), 32'h0);
   endtask

   logic [3:0] rr_grant [5];
   logic [7:0] rr_data  [5];

   initial begin
      rr_grant = '{4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
      rr_data  = '{8'h13, 8'h10, 8'h11, 8'h12, 8'h13};

      // Reset with stimulus active
      rst           = 1'b1;
      bus.req_valid = '1;
      bus.req_data  = 32'h44332211;
      bus.req_last  = '1;
      bus.out_ready = 1'b1;
      tick();
      #1;
      chk_reset_vals("rst");
      tick();
      rst = 1'b0;
      idle_all();
      tick();

      // Single packet from requester 2 (ptr=0)
      drv(2, 1'b1, 8'hA1, 1'b0);
      #1;
      chk("sp_idle_grant", 32'(bus.grant), 32'h0);
      chk("sp_idle_ready", 32'(bus.req_ready), 32'h0);
      tick();
      #1;
      chk("sp_grant", 32'(bus.grant), 32'h4);
      chk("sp_busy", 32'(bus.busy), 32'h1);
      chk("sp_ready", 32'(bus.req_ready), 32'h4);
      chk("sp_outv0", 32'(bus.out_valid), 32'h0);
      tick();
      drv(2, 1'b1, 8'hA2, 1'b0);
      #1;
      chk("sp_outv1", 32'(bus.out_valid), 32'h1);
      chk("sp_a1", 32'(bus.out_data), 32'hA1);
      chk("sp_a1_last", 32'(bus.out_last), 32'h0);
      chk("sp_grant_hold", 32'(bus.grant), 32'h4);
      tick();
      drv(2, 1'b1, 8'hA3, 1'b1);
      #1;
      chk("sp_a2", 32'(bus.out_data), 32'hA2);
      chk("sp_ready2", 32'(bus.req_ready), 32'h4);
      tick();
      drv(2, 1'b0, 8'h00, 1'b0);
      #1;
      chk("sp_a3", 32'(bus.out_data), 32'hA3);
      chk("sp_a3_last", 32'(bus.out_last), 32'h1);
      chk("sp_busy_drop", 32'(bus.busy), 32'h0);
      chk("sp_grant_drop", 32'(bus.grant), 32'h0);
      tick();

      // Round-robin, all requesters sending 1-beat packets; ptr=3 after the previous packet
      for (int i = 0; i < N; i++) drv(i, 1'b1, W'(16 + i), 1'b1);
      #1;
      chk("sp_drained", 32'(bus.out_valid), 32'h0);
      for (int k = 0; k < 5; k++) begin
         #1;
         chk("rr_bubble", 32'(bus.grant), 32'h0);
         if (k > 0) chk("rr_data", 32'(bus.out_data), 32'(rr_data[k-1]));
         tick();
         #1;
         chk("rr_grant", 32'(bus.grant), 32'(rr_grant[k]));
         chk("rr_ready", 32'(bus.req_ready), 32'(rr_grant[k]));
         tick();
      end
      idle_all();
      #1;
      chk("rr_bubble_end", 32'(bus.grant), 32'h0);
      chk("rr_data_end", 32'(bus.out_data), 32'(rr_data[4]));
      chk("rr_last_end", 32'(bus.out_last), 32'h1);
      tick();
      #1;
      chk("rr_drained", 32'(bus.out_valid), 32'h0);

      // Backpressure on requester 0 (ptr=0): 5 stall cycles mid-packet
      drv(0, 1'b1, 8'hB0, 1'b0);
      bus.out_ready = 1'b1;
      tick();
      #1;
      chk("bp_grant", 32'(bus.grant), 32'h1);
      chk("bp_ready", 32'(bus.req_ready), 32'h1);
      tick();
      drv(0, 1'b1, 8'hB1, 1'b0);
      bus.out_ready = 1'b0;
      for (int s = 0; s < 5; s++) begin
         #1;
         chk("bp_stall_valid", 32'(bus.out_valid), 32'h1);
         chk("bp_stall_data", 32'(bus.out_data), 32'hB0);
         chk("bp_stall_ready", 32'(bus.req_ready), 32'h0);
         tick();
      end
      bus.out_ready = 1'b1;
      #1;
      chk("bp_release_ready", 32'(bus.req_ready), 32'h1);
      chk("bp_release_data", 32'(bus.out_data), 32'hB0);
      tick();
      drv(0, 1'b1, 8'hB2, 1'b0);
      #1;
      chk("bp_b1", 32'(bus.out_data), 32'hB1);
      tick();
      drv(0, 1'b1, 8'hB3, 1'b1);
      #1;
      chk("bp_b2", 32'(bus.out_data), 32'hB2);
      tick();
      drv(0, 1'b0, 8'h00, 1'b0);
      #1;
      chk("bp_b3", 32'(bus.out_data), 32'hB3);
      chk("bp_b3_last", 32'(bus.out_last), 32'h1);
      chk("bp_busy_drop", 32'(bus.busy), 32'h0);
      tick();
      #1;
      chk("bp_drained", 32'(bus.out_valid), 32'h0);

      // Lock: req 0 mid-packet, req 1 arrives (ptr=1 but req 0 is alone at arbitration)
      drv(0, 1'b1, 8'hC0, 1'b0);
      tick();
      #1;
      chk("lk_grant0", 32'(bus.grant), 32'h1);
      tick();
      drv(0, 1'b1, 8'hC1, 1'b0);
      drv(1, 1'b1, 8'hD0, 1'b1);
      #1;
      chk("lk_hold_grant", 32'(bus.grant), 32'h1);
      chk("lk_hold_ready", 32'(bus.req_ready), 32'h1);
      tick();
      drv(0, 1'b1, 8'hC2, 1'b1);
      #1;
      chk("lk_hold_grant2", 32'(bus.grant), 32'h1);
      chk("lk_c1", 32'(bus.out_data), 32'hC1);
      tick();
      drv(0, 1'b0, 8'h00, 1'b0);
      #1;
      chk("lk_bubble", 32'(bus.grant), 32'h0);
      chk("lk_c2", 32'(bus.out_data), 32'hC2);
      tick();
      #1;
      chk("lk_grant1", 32'(bus.grant), 32'h2);
      chk("lk_ready1", 32'(bus.req_ready), 32'h2);
      tick();
      drv(1, 1'b0, 8'h00, 1'b0);
      #1;
      chk("lk_d0", 32'(bus.out_data), 32'hD0);
      chk("lk_d0_last", 32'(bus.out_last), 32'h1);
      chk("lk_grant_drop", 32'(bus.grant), 32'h0);
      tick();

      // Reset mid-packet: req 3 wins from ptr=2, reset lands on its second beat
      drv(3, 1'b1, 8'hE0, 1'b0);
      tick();
      #1;
      chk("mr_grant3", 32'(bus.grant), 32'h8);
      tick();
      drv(3, 1'b1, 8'hE1, 1'b0);
      rst = 1'b1;
      #1;
      chk("mr_e0", 32'(bus.out_data), 32'hE0);
      tick();
      rst = 1'b0;
      drv(3, 1'b1, 8'hE2, 1'b0);
      drv(0, 1'b1, 8'hF0, 1'b1);
      #1;
      chk_reset_vals("mr");
      tick();
      #1;
      chk("mr_rewin_grant", 32'(bus.grant), 32'h1);
      chk("mr_rewin_ready", 32'(bus.req_ready), 32'h1);
      tick();
      idle_all();
      #1;
      chk("mr_f0", 32'(bus.out_data), 32'hF0);
      chk("mr_f0_last", 32'(bus.out_last), 32'h1);
      chk("mr_grant_drop", 32'(bus.grant), 32'h0);
      tick();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
